ddr_iod_dly_sequencer: RTL and testbench

//  Sequences the per-lane dynamic delay-line controls (MOVE/DIRECTION/LOAD) of DDR4 address/command IODs.

---
 rtl/ddr_iod_dly_pkg.sv | 23 ++
 rtl/ddr_iod_dly_gap_timer.sv | 31 +++
 rtl/ddr_iod_dly_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_ddr_iod_dly_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_iod_dly_pkg.sv
// Shared types and constants for the IOD delay-line sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ddr_iod_dly_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_LGAP,
    ST_SETUP,
    ST_MOVE,
    ST_MGAP,
    ST_RESP
  } state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

  localparam int DEF_TAP_W    = 8;
  localparam int DEF_LOAD_TAP = 1;

endpackage

// File: rtl/ddr_iod_dly_gap_timer.sv
// Loadable down-counter that spaces delay-line pulses by GAP idle cycles.
// Latency: done asserts on the GAP-th cycle after load (the last idle cycle).
// Backpressure: none; load restarts the count at any time.
// Ports: clk, rst_n (sync, active-low), load (start a gap), done (last gap cycle).
module ddr_iod_dly_gap_timer #(
  parameter int GAP = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(GAP + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(GAP);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Count runs GAP..1 across the gap; value 1 marks its final cycle.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/ddr_iod_dly_sequencer.sv
// Steps a selected IOD lane's dynamic delay line to a requested tap using LOAD and single MOVE pulses.
// Latency: response at T0+3+N*(MOVE_GAP+1) for N steps, +MOVE_GAP+1 when a LOAD is requested; errors at T0+2.
// Backpressure: req_ready only in IDLE; requests presented while busy are ignored, not queued.
// Ports: fab_clk/reset_n (sync, active-low); req_* request handshake; rsp_* one-cycle completion with
//        final tap and error; busy; delay_line_* per-lane MOVE/DIRECTION/LOAD outputs and OUT_OF_RANGE input.
module ddr_iod_dly_sequencer
  import ddr_iod_dly_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 1,
  parameter int TAP_W     = DEF_TAP_W,
  parameter int TAP_MAX   = 255,
  parameter int LOAD_TAP  = DEF_LOAD_TAP,
  parameter int MOVE_GAP  = 3
) (
  input  logic                 fab_clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LANE_W-1:0]    req_lane,
  input  logic                 req_load,
  input  logic [TAP_W-1:0]     req_tap,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [TAP_W-1:0]     rsp_tap,
  output logic                 busy,
  output logic [NUM_LANES-1:0] delay_line_move,
  output logic [NUM_LANES-1:0] delay_line_direction,
  output logic [NUM_LANES-1:0] delay_line_load,
  input  logic [NUM_LANES-1:0] delay_line_out_of_range
);

  localparam logic [TAP_W-1:0] LOAD_TAP_V  = TAP_W'(LOAD_TAP);
  localparam logic [TAP_W:0]   TAP_MAX_V   = (TAP_W + 1)'(TAP_MAX);
  localparam logic [LANE_W:0]  NUM_LANES_V = (LANE_W + 1)'(NUM_LANES);

  state_t               state_q, state_d;
  logic                 alive_q;
  logic [LANE_W-1:0]    lane_q;
  logic [TAP_W-1:0]     tgt_q;
  logic                 load_q;
  logic [TAP_W-1:0]     cnt_q [NUM_LANES];
  logic [NUM_LANES-1:0] dir_q;
  logic                 rsp_err_q;
  logic [TAP_W-1:0]     rsp_tap_q;

  logic                 accept, lane_ok, tap_ok, dir_now, gap_done;
  logic [LANE_W-1:0]    lane_idx;
  logic [NUM_LANES-1:0] lane_oh;
  logic [TAP_W-1:0]     cur_tap, step_tap;
  logic                 timer_load, cnt_wr, dir_wr, rsp_cap, rsp_err_d;
  logic [TAP_W-1:0]     cnt_wd, rsp_tap_d;

  assign accept   = req_valid && req_ready;
  assign lane_ok  = ({1'b0, lane_q} < NUM_LANES_V);
  assign tap_ok   = ({1'b0, tgt_q} <= TAP_MAX_V);
  // A rejected lane never drives pulses; clamp the index so array reads stay in range.
  assign lane_idx = lane_ok ? lane_q : '0;
  assign lane_oh  = lane_ok ? (NUM_LANES'(1) << lane_idx) : '0;
  assign cur_tap  = cnt_q[lane_idx];
  assign dir_now  = (tgt_q > cur_tap) ? DIR_INC : DIR_DEC;
  assign step_tap = (dir_q[lane_idx] == DIR_INC) ? cur_tap + 1'b1 : cur_tap - 1'b1;

  ddr_iod_dly_gap_timer #(
    .GAP(MOVE_GAP)
  ) u_gap (
    .clk  (fab_clk),
    .rst_n(reset_n),
    .load (timer_load),
    .done (gap_done)
  );

  always_ff @(posedge fab_clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      alive_q   <= 1'b0;
      lane_q    <= '0;
      tgt_q     <= '0;
      load_q    <= 1'b0;
      dir_q     <= '0;
      rsp_err_q <= 1'b0;
      rsp_tap_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= LOAD_TAP_V;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (accept) begin
        lane_q <= req_lane;
        tgt_q  <= req_tap;
        load_q <= req_load;
      end
      if (cnt_wr) cnt_q[lane_idx] <= cnt_wd;
      if (dir_wr) dir_q[lane_idx] <= dir_now;
      if (rsp_cap) begin
        rsp_err_q <= rsp_err_d;
        rsp_tap_q <= rsp_tap_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    cnt_wr     = 1'b0;
    cnt_wd     = cur_tap;
    dir_wr     = 1'b0;
    rsp_cap    = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_tap_d  = cur_tap;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!lane_ok || !tap_ok) begin
          state_d   = ST_RESP;
          rsp_cap   = 1'b1;
          rsp_err_d = 1'b1;
          rsp_tap_d = lane_ok ? cur_tap : '0;
        end else if (load_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_LOAD: begin
        cnt_wr     = 1'b1;
        cnt_wd     = LOAD_TAP_V;
        timer_load = 1'b1;
        state_d    = ST_LGAP;
      end
      ST_LGAP: begin
        if (gap_done) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        // Direction settles here, a full cycle ahead of the first MOVE.
        dir_wr = 1'b1;
        if (tgt_q == cur_tap) begin
          state_d = ST_RESP;
          rsp_cap = 1'b1;
        end else begin
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        timer_load = 1'b1;
        state_d    = ST_MGAP;
      end
      ST_MGAP: begin
        if (gap_done) begin
          // A range flag means the IOD refused this step, so the counter keeps its old value.
          if (delay_line_out_of_range[lane_idx]) begin
            state_d   = ST_RESP;
            rsp_cap   = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            cnt_wr = 1'b1;
            cnt_wd = step_tap;
            if (step_tap == tgt_q) begin
              state_d   = ST_RESP;
              rsp_cap   = 1'b1;
              rsp_tap_d = step_tap;
            end else begin
              state_d = ST_MOVE;
            end
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    delay_line_direction = dir_q;
    if (state_q == ST_SETUP) delay_line_direction[lane_idx] = dir_now;
  end

  assign delay_line_move = (state_q == ST_MOVE) ? lane_oh : '0;
  assign delay_line_load = (state_q == ST_LOAD) ? lane_oh : '0;
  assign req_ready       = (state_q == ST_IDLE) && alive_q;
  assign busy            = (state_q != ST_IDLE);
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_err         = rsp_valid && rsp_err_q;
  assign rsp_tap         = rsp_tap_q;

endmodule

// File: tb/tb_ddr_iod_dly_sequencer.sv
// Self-checking bench for ddr_iod_dly_sequencer: directed scenarios plus randomized requests vs a tap model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ddr_iod_dly_sequencer;

  localparam int NL   = 3;
  localparam int LW   = 2;
  localparam int TW   = 9;
  localparam int TMAX = 255;
  localparam int LTAP = 1;
  localparam int GAP  = 3;

  logic          fab_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_load = 1'b0;
  logic [LW-1:0] req_lane = '0;
  logic [TW-1:0] req_tap = '0;
  logic          req_ready, rsp_valid, rsp_err, busy;
  logic [TW-1:0] rsp_tap;
  logic [NL-1:0] dl_move, dl_dir, dl_load;
  logic [NL-1:0] dl_oor = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int model_tap[NL];

  int   obs_lat, obs_moves, obs_loads, obs_first_move, obs_first_load;
  int   obs_gap_bad, obs_dir_chg, obs_stray, obs_busy_low;
  logic obs_err, obs_dir, obs_ready_pre, obs_busy_post, obs_ready_post;
  logic [TW-1:0] obs_tap;

  int   exp_lat, exp_moves, exp_loads, exp_tap, exp_first_move;
  logic exp_err, exp_dir;

  always #5 fab_clk = ~fab_clk;

  ddr_iod_dly_sequencer #(
    .NUM_LANES(NL), .LANE_W(LW), .TAP_W(TW), .TAP_MAX(TMAX), .LOAD_TAP(LTAP), .MOVE_GAP(GAP)
  ) dut (
    .fab_clk                (fab_clk),
    .reset_n                (reset_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_lane               (req_lane),
    .req_load               (req_load),
    .req_tap                (req_tap),
    .rsp_valid              (rsp_valid),
    .rsp_err                (rsp_err),
    .rsp_tap                (rsp_tap),
    .busy                   (busy),
    .delay_line_move        (dl_move),
    .delay_line_direction   (dl_dir),
    .delay_line_load        (dl_load),
    .delay_line_out_of_range(dl_oor)
  );

  // Reference: what a request should do, from lane/tap arithmetic alone.
  task automatic model_req(input int lane, input bit load, input int tap, input int oor_at);
    int start, steps;
    exp_loads = 0; exp_moves = 0; exp_err = 1'b0; exp_dir = 1'b0; exp_first_move = -1;
    if (lane >= NL || tap > TMAX) begin
      exp_err = 1'b1;
      exp_lat = 2;
      exp_tap = (lane < NL) ? model_tap[lane] : 0;
    end else begin
      start     = load ? LTAP : model_tap[lane];
      exp_loads = load ? 1 : 0;
      steps     = (tap > start) ? tap - start : start - tap;
      exp_dir   = (tap > start);
      exp_first_move = (steps == 0) ? -1 : 3 + exp_loads * (GAP + 1);
      if (oor_at >= 1 && oor_at <= steps) begin
        exp_moves = oor_at;
        exp_err   = 1'b1;
        exp_tap   = exp_dir ? start + (oor_at - 1) : start - (oor_at - 1);
      end else begin
        exp_moves = steps;
        exp_tap   = tap;
      end
      exp_lat = 3 + (exp_loads + exp_moves) * (GAP + 1);
      model_tap[lane] = exp_tap;
    end
  endtask

  // Drives one request and records what the DUT did, cycle-stamped from T0.
  task automatic do_req(input int lane, input bit load, input int tap, input int oor_at, input bit junk);
    int n, last_move;
    bit done;
    logic [NL-1:0] sel;
    sel = (lane < NL) ? (NL'(1) << lane) : '0;
    obs_moves = 0; obs_loads = 0; obs_first_move = -1; obs_first_load = -1;
    obs_gap_bad = 0; obs_dir_chg = 0; obs_stray = 0; obs_busy_low = 0;
    obs_dir = 1'b0; obs_err = 1'b0; obs_tap = '0;
    @(negedge fab_clk);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge fab_clk);
    obs_ready_pre = req_ready;
    req_valid = 1'b1; req_lane = LW'(lane); req_load = load; req_tap = TW'(tap);
    @(negedge fab_clk);
    n = 1; done = 1'b0; last_move = -1;
    while (!done && n < 400) begin
      if (junk) begin
        req_valid = 1'(($urandom() >> 3) & 1);
        req_lane  = LW'($urandom());
        req_tap   = TW'($urandom());
        req_load  = 1'($urandom());
      end else begin
        req_valid = 1'b0;
      end
      if (busy !== 1'b1) obs_busy_low++;
      if (|((dl_move | dl_load) & ~sel)) obs_stray++;
      if (|(dl_load & sel)) begin
        obs_loads++;
        if (obs_first_load < 0) obs_first_load = n;
      end
      if (|(dl_move & sel)) begin
        obs_moves++;
        if (last_move < 0) begin
          obs_first_move = n;
          obs_dir = |(dl_dir & sel);
        end else begin
          if (n - last_move != GAP + 1) obs_gap_bad++;
          if ((|(dl_dir & sel)) !== obs_dir) obs_dir_chg++;
        end
        last_move = n;
        if (obs_moves == oor_at) dl_oor = sel;
      end
      if (rsp_valid === 1'b1) begin
        done = 1'b1; obs_lat = n; obs_err = rsp_err; obs_tap = rsp_tap;
        req_valid = 1'b0;
      end else begin
        @(negedge fab_clk);
        n++;
      end
    end
    if (!done) begin
      obs_lat = -1;
      req_valid = 1'b0;
    end
    dl_oor = '0;
    @(negedge fab_clk);
    obs_busy_post  = busy;
    obs_ready_post = req_ready;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NL; i++) model_tap[i] = LTAP;
    reset_n = 1'b0;
    repeat (3) @(negedge fab_clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
    reset_n = 1'b1;
    @(negedge fab_clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_high: got %b expected 1", req_ready); end
    n_checks++;
    if ({dl_move, dl_dir, dl_load} !== '0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0 || rsp_tap !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: move=%b dir=%b load=%b rv=%b re=%b busy=%b tap=%0d expected all 0",
               dl_move, dl_dir, dl_load, rsp_valid, rsp_err, busy, rsp_tap);
    end
    model_req(0, 0, 1, 0);
    do_req(0, 0, 1, 0, 0);
    n_checks++; if (obs_tap !== TW'(exp_tap)) begin n_fail++; $display("FAIL reset_tap: got %0d expected %0d", obs_tap, exp_tap); end
    n_checks++; if (obs_lat !== exp_lat) begin n_fail++; $display("FAIL zero_step_lat: got %0d expected %0d", obs_lat, exp_lat); end
    n_checks++; if (obs_moves !== 0) begin n_fail++; $display("FAIL zero_step_moves: got %0d expected 0", obs_moves); end
  endtask

  task automatic test_step_up();
    model_req(0, 0, 4, 0);
    do_req(0, 0, 4, 0, 0);
    n_checks++; if (obs_moves !== exp_moves) begin n_fail++; $display("FAIL up_moves: got %0d expected %0d", obs_moves, exp_moves); end
    n_checks++; if (obs_dir !== exp_dir) begin n_fail++; $display("FAIL up_dir: got %b expected %b", obs_dir, exp_dir); end
    n_checks++; if (obs_gap_bad !== 0) begin n_fail++; $display("FAIL up_spacing: got %0d bad gaps expected 0", obs_gap_bad); end
    n_checks++; if (obs_lat !== exp_lat) begin n_fail++; $display("FAIL up_lat: got %0d expected %0d", obs_lat, exp_lat); end
    n_checks++; if (obs_tap !== TW'(exp_tap) || obs_err !== 1'b0) begin n_fail++; $display("FAIL up_rsp: got tap %0d err %b expected tap %0d err 0", obs_tap, obs_err, exp_tap); end
    n_checks++; if (obs_busy_low !== 0 || obs_busy_post !== 1'b0) begin n_fail++; $display("FAIL up_busy: got low=%0d post=%b expected 0/0", obs_busy_low, obs_busy_post); end
  endtask

  task automatic test_load_down();
    model_req(1, 1, 0, 0);
    do_req(1, 1, 0, 0, 0);
    n_checks++; if (obs_loads !== 1 || obs_first_load !== 2) begin n_fail++; $display("FAIL load_pulse: got %0d at %0d expected 1 at 2", obs_loads, obs_first_load); end
    n_checks++; if (obs_moves !== exp_moves || obs_first_move !== exp_first_move) begin n_fail++; $display("FAIL load_moves: got %0d at %0d expected %0d at %0d", obs_moves, obs_first_move, exp_moves, exp_first_move); end
    n_checks++; if (obs_dir !== 1'b0) begin n_fail++; $display("FAIL load_dir: got %b expected 0", obs_dir); end
    n_checks++; if (obs_tap !== TW'(exp_tap) || obs_lat !== exp_lat) begin n_fail++; $display("FAIL load_rsp: got tap %0d lat %0d expected %0d %0d", obs_tap, obs_lat, exp_tap, exp_lat); end
    n_checks++; if (obs_stray !== 0) begin n_fail++; $display("FAIL load_other_lane: got %0d stray cycles expected 0", obs_stray); end
  endtask

  task automatic test_bad_req();
    model_req(3, 0, 10, 0);
    do_req(3, 0, 10, 0, 0);
    n_checks++; if (obs_err !== 1'b1 || obs_lat !== 2) begin n_fail++; $display("FAIL bad_lane: got err %b lat %0d expected 1 2", obs_err, obs_lat); end
    n_checks++; if (obs_moves + obs_loads + obs_stray !== 0) begin n_fail++; $display("FAIL bad_lane_pulses: got %0d expected 0", obs_moves + obs_loads + obs_stray); end
    model_req(0, 1, 256, 0);
    do_req(0, 1, 256, 0, 0);
    n_checks++; if (obs_err !== 1'b1 || obs_lat !== 2) begin n_fail++; $display("FAIL bad_tap: got err %b lat %0d expected 1 2", obs_err, obs_lat); end
    n_checks++; if (obs_tap !== TW'(exp_tap) || obs_moves + obs_loads !== 0) begin n_fail++; $display("FAIL bad_tap_state: got tap %0d pulses %0d expected %0d 0", obs_tap, obs_moves + obs_loads, exp_tap); end
  endtask

  task automatic test_out_of_range();
    model_req(0, 1, 1, 0);
    do_req(0, 1, 1, 0, 0);
    n_checks++; if (obs_tap !== TW'(exp_tap)) begin n_fail++; $display("FAIL oor_preload: got %0d expected %0d", obs_tap, exp_tap); end
    model_req(0, 0, 6, 2);
    do_req(0, 0, 6, 2, 0);
    n_checks++; if (obs_err !== 1'b1 || obs_tap !== TW'(exp_tap)) begin n_fail++; $display("FAIL oor_rsp: got err %b tap %0d expected 1 %0d", obs_err, obs_tap, exp_tap); end
    n_checks++; if (obs_moves !== 2 || obs_lat !== exp_lat) begin n_fail++; $display("FAIL oor_moves: got %0d lat %0d expected 2 %0d", obs_moves, obs_lat, exp_lat); end
  endtask

  task automatic test_reset_mid();
    int seen_rsp;
    seen_rsp = 0;
    @(negedge fab_clk);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge fab_clk);
    req_valid = 1'b1; req_lane = LW'(2); req_load = 1'b0; req_tap = TW'(9);
    @(negedge fab_clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && dl_move[2] !== 1'b1; i++) @(negedge fab_clk);
    n_checks++; if (dl_move[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_move: got %b expected 1", dl_move[2]); end
    @(negedge fab_clk);
    reset_n = 1'b0;
    @(negedge fab_clk);
    n_checks++;
    if ({dl_move, dl_dir, dl_load} !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: move=%b dir=%b load=%b rv=%b busy=%b expected 0", dl_move, dl_dir, dl_load, rsp_valid, busy);
    end
    repeat (2) begin
      @(negedge fab_clk);
      if (rsp_valid === 1'b1) seen_rsp++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < NL; i++) model_tap[i] = LTAP;
    for (int i = 0; i < 30; i++) begin
      @(negedge fab_clk);
      if (rsp_valid === 1'b1) seen_rsp++;
    end
    n_checks++; if (seen_rsp !== 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d responses expected 0", seen_rsp); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", req_ready); end
    model_req(2, 0, 1, 0);
    do_req(2, 0, 1, 0, 0);
    n_checks++; if (obs_tap !== TW'(exp_tap) || obs_lat !== exp_lat) begin n_fail++; $display("FAIL midrst_tap: got tap %0d lat %0d expected %0d %0d", obs_tap, obs_lat, exp_tap, exp_lat); end
  endtask

  task automatic test_random();
    int lane, tap, oor_at;
    bit load;
    for (int k = 0; k < 14; k++) begin
      lane   = int'($urandom_range(0, 3));
      load   = 1'($urandom_range(0, 1));
      tap    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 300)) : int'($urandom_range(0, 12));
      oor_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      model_req(lane, load, tap, oor_at);
      do_req(lane, load, tap, oor_at, 1'b1);
      n_checks++; if (obs_lat !== exp_lat) begin n_fail++; $display("FAIL rnd%0d_lat: got %0d expected %0d", k, obs_lat, exp_lat); end
      n_checks++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b expected %b", k, obs_err, exp_err); end
      if (lane < NL) begin
        n_checks++; if (obs_tap !== TW'(exp_tap)) begin n_fail++; $display("FAIL rnd%0d_tap: got %0d expected %0d", k, obs_tap, exp_tap); end
      end
      n_checks++; if (obs_moves !== exp_moves || obs_loads !== exp_loads) begin n_fail++; $display("FAIL rnd%0d_pulses: got mv %0d ld %0d expected %0d %0d", k, obs_moves, obs_loads, exp_moves, exp_loads); end
      n_checks++; if (obs_first_move !== exp_first_move) begin n_fail++; $display("FAIL rnd%0d_first_move: got %0d expected %0d", k, obs_first_move, exp_first_move); end
      if (exp_moves > 0) begin
        n_checks++; if (obs_dir !== exp_dir || obs_dir_chg !== 0) begin n_fail++; $display("FAIL rnd%0d_dir: got %b chg %0d expected %b 0", k, obs_dir, obs_dir_chg, exp_dir); end
      end
      n_checks++; if (obs_gap_bad + obs_stray + obs_busy_low !== 0) begin n_fail++; $display("FAIL rnd%0d_timing: got gap %0d stray %0d busy %0d expected 0", k, obs_gap_bad, obs_stray, obs_busy_low); end
      n_checks++; if (obs_ready_pre !== 1'b1 || obs_ready_post !== 1'b1 || obs_busy_post !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_handshake: got pre %b post %b busy %b expected 1 1 0", k, obs_ready_pre, obs_ready_post, obs_busy_post); end
    end
  endtask

  initial begin
    test_reset();
    test_step_up();
    test_load_down();
    test_bad_req();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
